input_fifo_rd_ctrl: RTL and testbench

Read-side sequencer for the EVT 2.0 input FIFO. It drives the FIFO's `rd_en` and absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer. The FIFO's output becomes a valid/ready stream that sustains 1 word/cycle into the EVT 2.0 decoder. The block also provides a flush sequence that drains the FIFO, and an optional overflow drop counter on the write side.

---
 rtl/input_fifo_rd_ctrl.sv | 134 +++++++++++++
 tb/tb_input_fifo_rd_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_fifo_rd_ctrl.sv
// rtl/input_fifo_rd_ctrl.sv - EVT 2.0 input FIFO read sequencer with 2-entry skid buffer and flush
// Optional write-side overflow drop counter enabled by INPUT_FIFO_RD_CTRL_DROP_CNT_EN.
`timescale 1ns/1ps

module input_fifo_rd_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int DROP_CNT_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  input  logic                     fifo_full,
  input  logic [DATA_WIDTH-1:0]    fifo_rd_data,
  output logic                     fifo_rd_en,
  input  logic                     src_wr_en,
  output logic                     m_valid,
  output logic [DATA_WIDTH-1:0]    m_data,
  input  logic                     m_ready,
  input  logic                     flush,
  output logic                     flushing,
  input  logic                     drop_clr,
  output logic [DROP_CNT_BITS-1:0] drop_count
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_inflight;
  logic [1:0]            r_occ;
  logic [1:0]            w_occ_nxt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_tail_nxt;
  logic                  r_flushing;
  logic                  w_pop_out;
  logic                  w_capture;
  logic [2:0]            w_pending;

  assign m_valid   = (r_occ != 2'd0);
  assign m_data    = r_head;
  assign flushing  = r_flushing;
  assign w_pop_out = m_valid && m_ready;
  assign w_capture = r_inflight && (r_state == ST_RUN);
  // Words owned by the buffer after this edge; a pop is only issued if it leaves room for one more.
  assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop_out};

  always_comb begin
    w_state_nxt = r_state;
    w_occ_nxt   = r_occ;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    fifo_rd_en  = 1'b0;
    case (r_state)
      ST_RUN: begin
        fifo_rd_en = !fifo_empty && (w_pending <= 3'd1);
        case ({w_capture, w_pop_out})
          2'b10: begin
            if (r_occ == 2'd0) begin
              w_head_nxt = fifo_rd_data;
              w_occ_nxt  = 2'd1;
            end else begin
              w_tail_nxt = fifo_rd_data;
              w_occ_nxt  = 2'd2;
            end
          end
          2'b01: begin
            if (r_occ == 2'd2) w_head_nxt = r_tail;
            w_occ_nxt = r_occ - 2'd1;
          end
          // Capture and pop together: head advances, occupancy unchanged.
          2'b11: begin
            if (r_occ == 2'd1) begin
              w_head_nxt = fifo_rd_data;
            end else begin
              w_head_nxt = r_tail;
              w_tail_nxt = fifo_rd_data;
            end
          end
          default: ;
        endcase
        if (flush) begin
          w_state_nxt = ST_FLUSH;
          w_occ_nxt   = 2'd0;
        end
      end
      ST_FLUSH: begin
        fifo_rd_en = !fifo_empty;
        if (fifo_empty && !r_inflight && !flush) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
    if (rst) fifo_rd_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
      r_flushing <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= fifo_rd_en;
      r_occ      <= w_occ_nxt;
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_flushing <= (w_state_nxt == ST_FLUSH);
    end
  end

`ifdef INPUT_FIFO_RD_CTRL_DROP_CNT_EN
  logic [DROP_CNT_BITS-1:0] r_drop_count;

  assign drop_count = r_drop_count;

  always_ff @(posedge clk) begin
    if (rst || drop_clr) begin
      r_drop_count <= '0;
    end else if (src_wr_en && fifo_full && (r_drop_count != {DROP_CNT_BITS{1'b1}})) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end
`else
  logic w_unused_drop;

  assign w_unused_drop = src_wr_en ^ fifo_full ^ drop_clr;
  assign drop_count    = '0;
`endif

endmodule

// File: tb/tb_input_fifo_rd_ctrl.sv
// tb/tb_input_fifo_rd_ctrl.sv - scoreboard bench for input_fifo_rd_ctrl with behavioural registered-read FIFO
`timescale 1ns/1ps

module tb_input_fifo_rd_ctrl;
  localparam int DW    = 32;
  localparam int DCB   = 16;
  localparam int DEPTH = 16;
`ifdef INPUT_FIFO_RD_CTRL_DROP_CNT_EN
  localparam logic [DCB-1:0] EXP_DROP5 = 16'd5;
  localparam logic [DCB-1:0] EXP_SAT   = 16'hFFFF;
`else
  localparam logic [DCB-1:0] EXP_DROP5 = 16'd0;
  localparam logic [DCB-1:0] EXP_SAT   = 16'd0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           fifo_empty;
  logic           fifo_full;
  logic [DW-1:0]  fifo_rd_data;
  logic           fifo_rd_en;
  logic           src_wr_en;
  logic           m_valid;
  logic [DW-1:0]  m_data;
  logic           m_ready;
  logic           flush;
  logic           flushing;
  logic           drop_clr;
  logic [DCB-1:0] drop_count;

  always #5 clk = ~clk;

  input_fifo_rd_ctrl #(.DATA_WIDTH(DW), .DROP_CNT_BITS(DCB)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .src_wr_en(src_wr_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .flush(flush),
    .flushing(flushing), .drop_clr(drop_clr), .drop_count(drop_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO: registered read data, shares rst with the DUT.
  logic [DW-1:0] fq[$];
  int            fcnt;
  int            bulk_n;
  logic [DW-1:0] bulk_base;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] pop_tmp;

  assign fifo_empty = (fcnt == 0);
  assign fifo_full  = (fcnt >= DEPTH);

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fcnt         <= 0;
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && !fifo_empty) begin
        pop_tmp = fq.pop_front();
        fifo_rd_data <= pop_tmp;
      end
      if (src_wr_en && !fifo_full) fq.push_back(wr_data);
      for (int i = 0; i < bulk_n; i++) fq.push_back(bulk_base + DW'(i));
      fcnt <= fq.size();
    end
  end

  // Monitor: pops expected words on every accepted beat.
  logic [DW-1:0] exp_q[$];
  int            beats       = 0;
  int            outstanding = 0;
  logic          prev_stall  = 1'b0;
  logic [DW-1:0] prev_data   = '0;

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      check("no_pop_when_empty", fifo_rd_en && fifo_empty, 0);
      if (prev_stall && m_valid) check("m_data_hold", m_data, prev_data);
      if (flushing) begin
        check("m_valid_in_flush", m_valid, 0);
        outstanding = 0;
      end else begin
        outstanding = outstanding + int'(fifo_rd_en && !fifo_empty) - int'(m_valid && m_ready);
        check("outstanding_le_2", outstanding <= 2, 1);
      end
      if (m_valid && m_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t", m_data, $time);
        end else begin
          check("beat_data", m_data, exp_q.pop_front());
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_flush_done(input string name);
    int n;
    n = 0;
    while (flushing && n < 60) begin
      tick();
      n++;
    end
    check(name, flushing, 0);
  endtask

  initial begin
    int n, lat, run, b0;
    rst = 1'b1; src_wr_en = 1'b0; m_ready = 1'b0; flush = 1'b0; drop_clr = 1'b0;
    wr_data = '0; bulk_n = 0; bulk_base = '0;
    repeat (3) tick();
    check("rst_fifo_rd_en", fifo_rd_en, 0);
    rst = 1'b0;
    tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_flushing", flushing, 0);
    check("rst_drop_count", drop_count, 0);

    // Streaming: 16 preloaded words, ready held high.
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h1000_0000 + DW'(i));
    bulk_base = 32'h1000_0000; bulk_n = 16;
    tick();
    bulk_n = 0;
    @(negedge clk);
    n = 0;
    while (!fifo_rd_en && n < 10) begin @(negedge clk); n++; end
    check("stream_first_pop", fifo_rd_en, 1);
    lat = 0;
    while (!m_valid && lat < 10) begin @(negedge clk); lat++; end
    check("stream_latency", lat, 2);
    run = 0;
    while (m_valid && run < 40) begin run++; @(negedge clk); end
    check("stream_run_len", run, 16);
    wait_drain("stream_drained");

    // Backpressure: ready 1,0,0,1,...
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h2000_0000 + DW'(i));
    bulk_base = 32'h2000_0000; bulk_n = 8; m_ready = 1'b0;
    tick();
    bulk_n = 0;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      m_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    check("bp_drained", exp_q.size(), 0);

    // Single word into an empty FIFO.
    m_ready = 1'b1;
    b0 = beats;
    wr_data = 32'hDEAD_BEEF; src_wr_en = 1'b1; exp_q.push_back(32'hDEAD_BEEF);
    tick();
    src_wr_en = 1'b0;
    repeat (6) tick();
    check("empty_edge_beats", beats - b0, 1);

    // Flush with 10 queued words and ready low.
    m_ready = 1'b0;
    bulk_base = 32'h3000_0000; bulk_n = 10;
    tick();
    bulk_n = 0;
    repeat (3) tick();
    b0 = beats;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flushing_set", flushing, 1);
    check("flush_m_valid", m_valid, 0);
    wait_flush_done("flush_done");
    check("flush_fifo_empty", fifo_empty, 1);
    check("flush_beats", beats - b0, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 32'h4000_0000 + DW'(i); src_wr_en = 1'b1; exp_q.push_back(wr_data);
      tick();
    end
    src_wr_en = 1'b0;
    wait_drain("post_flush_drained");

    // Drop counter.
    m_ready = 1'b0;
    n = 0;
    while (!fifo_full && n < 40) begin
      wr_data = 32'h7000_0000 + DW'(n); src_wr_en = 1'b1;
      tick();
      n++;
    end
    src_wr_en = 1'b0;
    check("drop_fifo_full", fifo_full, 1);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    src_wr_en = 1'b1;
    repeat (5) tick();
    src_wr_en = 1'b0;
    check("drop_count_5", drop_count, EXP_DROP5);
    drop_clr = 1'b1; src_wr_en = 1'b1;
    tick();
    drop_clr = 1'b0; src_wr_en = 1'b0;
    check("drop_clr_priority", drop_count, 0);
`ifdef INPUT_FIFO_RD_CTRL_DROP_CNT_EN
    src_wr_en = 1'b1;
    repeat (65539) tick();
    src_wr_en = 1'b0;
`endif
    check("drop_saturate", drop_count, EXP_SAT);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_flush_done("drop_flush_done");

    // Reset in the middle of a transfer.
    bulk_base = 32'h5000_0000; bulk_n = 6;
    tick();
    bulk_n = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_drop_count", drop_count, 0);
    check("midrst_fifo_rd_en", fifo_rd_en, 0);
    rst = 1'b0;
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h6000_0000 + DW'(i));
    bulk_base = 32'h6000_0000; bulk_n = 4;
    tick();
    bulk_n = 0;
    wait_drain("post_rst_drained");

    repeat (4) tick();
    check("final_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
